// File: rtl/rename_alloc_ctrl.sv
// Rename-stage controller: circular physical-register free list, 2-wide allocation,
// intra-bundle source bypass and commit recycling. Define RENAME_STALL_CNT_EN for the stall counter.
module rename_alloc_ctrl #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 48
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      dec_valid,
  input  logic [1:0][4:0] dec_rs1,
  input  logic [1:0][4:0] dec_rs2,
  input  logic [1:0][4:0] dec_rd,
  input  logic [1:0]      dec_wr_en,
  output logic            dec_ready,
  output logic [1:0][4:0] rt_arch_rs1,
  output logic [1:0][4:0] rt_arch_rs2,
  input  logic [1:0][5:0] rt_phys_rs1,
  input  logic [1:0][5:0] rt_phys_rs2,
  output logic [1:0]      rt_rename_en,
  output logic [1:0][4:0] rt_arch_rd,
  output logic [1:0][5:0] rt_new_phys_rd,
  output logic [1:0]      ren_valid,
  output logic [1:0][5:0] ren_phys_rs1,
  output logic [1:0][5:0] ren_phys_rs2,
  output logic [1:0][5:0] ren_phys_rd,
  input  logic            ren_ready,
  input  logic [1:0]      commit_en,
  input  logic [1:0][5:0] commit_free_phys,
  input  logic            flush,
  output logic [4:0]      free_count,
  output logic [31:0]     stall_cycles
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;

  logic [5:0] fl [FL_DEPTH];
  logic [3:0] spec_head, commit_head, tail;
  logic [4:0] spec_count, commit_count;

  logic [1:0]      alloc;
  logic [1:0]      need, n_commit;
  logic            accept;
  logic [3:0]      idx1;
  logic [5:0]      new0, new1;
  logic [1:0][5:0] src1, src2;

  assign alloc[0] = dec_valid[0] & dec_wr_en[0] & (dec_rd[0] != 5'd0);
  assign alloc[1] = dec_valid[1] & dec_wr_en[1] & (dec_rd[1] != 5'd0);
  assign need     = 2'(alloc[0]) + 2'(alloc[1]);
  assign n_commit = 2'(commit_en[0]) + 2'(commit_en[1]);

  assign dec_ready = !flush & (~|ren_valid | ren_ready) & (spec_count >= 5'(need));
  assign accept    = dec_ready & dec_valid[0];

  assign idx1 = spec_head + 4'(alloc[0]);
  assign new0 = fl[spec_head];
  assign new1 = fl[idx1];

  assign rt_arch_rs1       = dec_rs1;
  assign rt_arch_rs2       = dec_rs2;
  assign rt_arch_rd        = dec_rd;
  assign rt_rename_en      = {2{accept}} & alloc;
  assign rt_new_phys_rd[0] = alloc[0] ? new0 : 6'd0;
  assign rt_new_phys_rd[1] = alloc[1] ? new1 : 6'd0;
  assign free_count        = spec_count;

  // Slot 1 sources see slot 0's fresh destination before the table has been written.
  always_comb begin
    src1[0] = (dec_rs1[0] == 5'd0) ? 6'd0 : rt_phys_rs1[0];
    src2[0] = (dec_rs2[0] == 5'd0) ? 6'd0 : rt_phys_rs2[0];
    src1[1] = rt_phys_rs1[1];
    src2[1] = rt_phys_rs2[1];
    if (dec_rs1[1] == 5'd0)
      src1[1] = 6'd0;
    else if (alloc[0] && dec_rs1[1] == dec_rd[0])
      src1[1] = new0;
    if (dec_rs2[1] == 5'd0)
      src2[1] = 6'd0;
    else if (alloc[0] && dec_rs2[1] == dec_rd[0])
      src2[1] = new0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= 6'(ARCH_REGS + i);
    end else begin
      if (commit_en[0]) fl[tail] <= commit_free_phys[0];
      if (commit_en[1]) fl[tail + 4'(commit_en[0])] <= commit_free_phys[1];
    end
  end

  // Flush rewinds speculation to the committed head, including this cycle's commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_head    <= 4'd0;
      commit_head  <= 4'd0;
      tail         <= 4'd0;
      spec_count   <= 5'(FL_DEPTH);
      commit_count <= 5'(FL_DEPTH);
    end else begin
      tail        <= tail + 4'(n_commit);
      commit_head <= commit_head + 4'(n_commit);
      if (flush) begin
        spec_head  <= commit_head + 4'(n_commit);
        spec_count <= commit_count;
      end else begin
        spec_head  <= spec_head + (accept ? 4'(need) : 4'd0);
        spec_count <= spec_count - (accept ? 5'(need) : 5'd0) + 5'(n_commit);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ren_valid    <= 2'b00;
      ren_phys_rs1 <= '0;
      ren_phys_rs2 <= '0;
      ren_phys_rd  <= '0;
    end else if (flush) begin
      ren_valid <= 2'b00;
    end else if (accept) begin
      ren_valid    <= dec_valid;
      ren_phys_rs1 <= src1;
      ren_phys_rs2 <= src2;
      ren_phys_rd  <= rt_new_phys_rd;
    end else if (ren_ready) begin
      ren_valid <= 2'b00;
    end
  end

`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_q <= 32'd0;
    else if (dec_valid[0] && !flush && spec_count < 5'(need) && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && |commit_en)
      assert (spec_count + 5'(n_commit) <= 5'(FL_DEPTH));
  end
`endif

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl; models the external rename table and checks
// hand-computed allocations, bypass, backpressure, flush, stall and reset behaviour.
module tb_rename_alloc_ctrl;

  logic            clk, reset;
  logic [1:0]      dec_valid, dec_wr_en;
  logic [1:0][4:0] dec_rs1, dec_rs2, dec_rd;
  logic            dec_ready;
  logic [1:0][4:0] rt_arch_rs1, rt_arch_rs2, rt_arch_rd;
  logic [1:0][5:0] rt_phys_rs1, rt_phys_rs2, rt_new_phys_rd;
  logic [1:0]      rt_rename_en, ren_valid;
  logic [1:0][5:0] ren_phys_rs1, ren_phys_rs2, ren_phys_rd;
  logic            ren_ready;
  logic [1:0]      commit_en;
  logic [1:0][5:0] commit_free_phys;
  logic            flush;
  logic [4:0]      free_count;
  logic [31:0]     stall_cycles;

  int passed = 0;
  int failed = 0;
  int total  = 0;

`ifdef RENAME_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  rename_alloc_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_wr_en(dec_wr_en), .dec_ready(dec_ready),
    .rt_arch_rs1(rt_arch_rs1), .rt_arch_rs2(rt_arch_rs2),
    .rt_phys_rs1(rt_phys_rs1), .rt_phys_rs2(rt_phys_rs2),
    .rt_rename_en(rt_rename_en), .rt_arch_rd(rt_arch_rd), .rt_new_phys_rd(rt_new_phys_rd),
    .ren_valid(ren_valid), .ren_phys_rs1(ren_phys_rs1), .ren_phys_rs2(ren_phys_rs2),
    .ren_phys_rd(ren_phys_rd), .ren_ready(ren_ready),
    .commit_en(commit_en), .commit_free_phys(commit_free_phys),
    .flush(flush), .free_count(free_count), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External speculative rename table: identity at reset, slot 1 written after slot 0.
  logic [5:0] map [32];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) map[i] <= 6'(i);
    end else begin
      if (rt_rename_en[0] && !rt_rename_en[1]) map[rt_arch_rd[0]] <= rt_new_phys_rd[0];
      if (rt_rename_en[1] && !rt_rename_en[0]) map[rt_arch_rd[1]] <= rt_new_phys_rd[1];
      if (rt_rename_en == 2'b11) begin
        if (rt_arch_rd[0] != rt_arch_rd[1]) map[rt_arch_rd[0]] <= rt_new_phys_rd[0];
        map[rt_arch_rd[1]] <= rt_new_phys_rd[1];
      end
    end
  end
  assign rt_phys_rs1[0] = map[rt_arch_rs1[0]];
  assign rt_phys_rs1[1] = map[rt_arch_rs1[1]];
  assign rt_phys_rs2[0] = map[rt_arch_rs2[0]];
  assign rt_phys_rs2[1] = map[rt_arch_rs2[1]];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_bundle(input logic [1:0] v, input logic [1:0] wr,
                              input logic [4:0] rd0, input logic [4:0] a0, input logic [4:0] b0,
                              input logic [4:0] rd1, input logic [4:0] a1, input logic [4:0] b1);
    dec_valid  = v;
    dec_wr_en  = wr;
    dec_rd[0]  = rd0; dec_rs1[0] = a0; dec_rs2[0] = b0;
    dec_rd[1]  = rd1; dec_rs1[1] = a1; dec_rs2[1] = b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ren_ready = 1'b1;
    flush = 1'b0;
    commit_en = 2'b00;
    commit_free_phys = '0;
    apply_bundle(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("reset_free_count", free_count, 16);
    check_eq("reset_ren_valid", ren_valid, 0);
    check_eq("reset_ren_phys_rd", ren_phys_rd, 0);
    check_eq("reset_stall", stall_cycles, 0);
    check_eq("reset_dec_ready", dec_ready, 1);

    // First bundle X1, X2 -> 32, 33
    apply_bundle(2'b11, 2'b11, 1, 0, 0, 2, 0, 0);
    #1;
    check_eq("b1_dec_ready", dec_ready, 1);
    check_eq("b1_rename_en", rt_rename_en, 2'b11);
    check_eq("b1_new0", rt_new_phys_rd[0], 32);
    check_eq("b1_new1", rt_new_phys_rd[1], 33);
    next_cycle();
    check_eq("b1_ren_valid", ren_valid, 2'b11);
    check_eq("b1_ren_rd0", ren_phys_rd[0], 32);
    check_eq("b1_ren_rd1", ren_phys_rd[1], 33);
    check_eq("b1_free", free_count, 14);

    // Bypass: slot1 reads X3 written by slot0
    apply_bundle(2'b11, 2'b11, 3, 1, 2, 4, 3, 1);
    #1;
    check_eq("b2_new0", rt_new_phys_rd[0], 34);
    check_eq("b2_new1", rt_new_phys_rd[1], 35);
    next_cycle();
    check_eq("b2_rs1_0", ren_phys_rs1[0], 32);
    check_eq("b2_rs2_0", ren_phys_rs2[0], 33);
    check_eq("b2_bypass_rs1_1", ren_phys_rs1[1], 34);
    check_eq("b2_rs2_1", ren_phys_rs2[1], 32);
    check_eq("b2_rd1", ren_phys_rd[1], 35);
    check_eq("b2_free", free_count, 12);

    // rd = X0 with write enable: no allocation; X3 lookup sees new mapping
    apply_bundle(2'b01, 2'b01, 0, 3, 0, 0, 0, 0);
    #1;
    check_eq("x0_rename_en", rt_rename_en, 0);
    check_eq("x0_dec_ready", dec_ready, 1);
    next_cycle();
    check_eq("x0_ren_valid", ren_valid, 2'b01);
    check_eq("x0_ren_rd", ren_phys_rd[0], 0);
    check_eq("x0_rs1", ren_phys_rs1[0], 34);
    check_eq("x0_rs2", ren_phys_rs2[0], 0);
    check_eq("x0_free", free_count, 12);

    // Backpressure: bundle A held for 3 cycles
    apply_bundle(2'b11, 2'b11, 5, 4, 0, 6, 0, 0);
    next_cycle();
    check_eq("a_rd0", ren_phys_rd[0], 36);
    check_eq("a_rs1_0", ren_phys_rs1[0], 35);
    ren_ready = 1'b0;
    apply_bundle(2'b01, 2'b01, 7, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("hold_dec_ready", dec_ready, 0);
      check_eq("hold_rename_en", rt_rename_en, 0);
      next_cycle();
      check_eq("hold_ren_valid", ren_valid, 2'b11);
      check_eq("hold_rd0", ren_phys_rd[0], 36);
      check_eq("hold_rd1", ren_phys_rd[1], 37);
      check_eq("hold_free", free_count, 10);
    end
    ren_ready = 1'b1;
    #1;
    check_eq("release_dec_ready", dec_ready, 1);
    check_eq("release_new0", rt_new_phys_rd[0], 38);
    next_cycle();
    check_eq("release_ren_valid", ren_valid, 2'b01);
    check_eq("release_rd0", ren_phys_rd[0], 38);
    check_eq("release_free", free_count, 9);

    // Flush with one commit returning 5
    flush = 1'b1;
    commit_en = 2'b01;
    commit_free_phys[0] = 6'd5;
    apply_bundle(2'b11, 2'b11, 8, 0, 0, 9, 0, 0);
    #1;
    check_eq("flush_dec_ready", dec_ready, 0);
    check_eq("flush_rename_en", rt_rename_en, 0);
    next_cycle();
    flush = 1'b0;
    commit_en = 2'b00;
    #1;
    check_eq("flush_free", free_count, 16);
    check_eq("flush_ren_valid", ren_valid, 0);
    check_eq("postflush_new0", rt_new_phys_rd[0], 33);
    check_eq("postflush_new1", rt_new_phys_rd[1], 34);
    next_cycle();
    check_eq("postflush_free", free_count, 14);

    // Drain the free list to empty
    for (int b = 0; b < 7; b++) begin
      apply_bundle(2'b11, 2'b11, 10, 0, 0, 11, 0, 0);
      next_cycle();
    end
    check_eq("empty_free", free_count, 0);

    // Stall: two-dest bundle needs two commits before it can go
    apply_bundle(2'b11, 2'b11, 12, 0, 0, 13, 0, 0);
    commit_en = 2'b01;
    commit_free_phys[0] = 6'd20;
    #1;
    check_eq("stall_dec_ready0", dec_ready, 0);
    next_cycle();
    commit_free_phys[0] = 6'd21;
    #1;
    check_eq("stall_free1", free_count, 1);
    check_eq("stall_dec_ready1", dec_ready, 0);
    check_eq("stall_cnt1", stall_cycles, STALL_EN ? 1 : 0);
    next_cycle();
    commit_en = 2'b00;
    #1;
    check_eq("stall_free2", free_count, 2);
    check_eq("stall_cnt2", stall_cycles, STALL_EN ? 2 : 0);
    check_eq("unstall_dec_ready", dec_ready, 1);
    check_eq("unstall_new0", rt_new_phys_rd[0], 20);
    check_eq("unstall_new1", rt_new_phys_rd[1], 21);
    next_cycle();
    apply_bundle(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    check_eq("unstall_rd0", ren_phys_rd[0], 20);
    check_eq("unstall_rd1", ren_phys_rd[1], 21);
    check_eq("unstall_free", free_count, 0);
    check_eq("unstall_cnt", stall_cycles, STALL_EN ? 2 : 0);

    // Dual commit in one cycle: slot order into the tail
    commit_en = 2'b11;
    commit_free_phys[0] = 6'd22;
    commit_free_phys[1] = 6'd23;
    next_cycle();
    commit_en = 2'b00;
    check_eq("dual_commit_free", free_count, 2);
    apply_bundle(2'b11, 2'b11, 14, 0, 0, 15, 0, 0);
    #1;
    check_eq("dual_new0", rt_new_phys_rd[0], 22);
    check_eq("dual_new1", rt_new_phys_rd[1], 23);
    next_cycle();
    apply_bundle(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    check_eq("dual_free_after", free_count, 0);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    check_eq("areset_free", free_count, 16);
    check_eq("areset_ren_valid", ren_valid, 0);
    check_eq("areset_stall", stall_cycles, 0);
    #1 reset = 1'b0;
    apply_bundle(2'b01, 2'b01, 1, 0, 0, 0, 0, 0);
    #1;
    check_eq("areset_new0", rt_new_phys_rd[0], 32);
    next_cycle();
    apply_bundle(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    check_eq("areset_free_after", free_count, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
